// File: rtl/mc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// mc_fifo_pkg
//   Shared helpers for the multi-channel round-robin FIFO (mc_fifo_rr).
//   - ptr_empty / ptr_full : classify a binary write/read pointer pair of
//     (ld+1) bits, where ld is the per-channel LOG_DEPTH. Pointers are passed
//     zero-extended to MAX_PW bits so one function serves every depth.
//   - rr_next : index of the first requesting channel at or after prio,
//     wrapping modulo n. The result is only meaningful when req has a bit set.
// -----------------------------------------------------------------------------
package mc_fifo_pkg;

  localparam int unsigned MAX_CH = 32;  // widest request vector rr_next handles
  localparam int unsigned MAX_PW = 16;  // widest pointer the ptr helpers handle

  // Empty: the low (ld+1) bits of both pointers are identical.
  function automatic logic ptr_empty(input logic [MAX_PW-1:0] wp,
                                     input logic [MAX_PW-1:0] rp,
                                     input int unsigned       ld);
    logic [MAX_PW-1:0] mask;
    mask = (MAX_PW'(1) << (ld + 1)) - MAX_PW'(1);
    return ((wp ^ rp) & mask) == '0;
  endfunction

  // Full: the wrap bit (bit ld) differs while all index bits agree.
  function automatic logic ptr_full(input logic [MAX_PW-1:0] wp,
                                    input logic [MAX_PW-1:0] rp,
                                    input int unsigned       ld);
    logic [MAX_PW-1:0] mask;
    mask = (MAX_PW'(1) << (ld + 1)) - MAX_PW'(1);
    return ((wp ^ rp) & mask) == (MAX_PW'(1) << ld);
  endfunction

  // Round-robin search starting at prio. prio is expected to be < n.
  function automatic int unsigned rr_next(input int unsigned       prio,
                                          input logic [MAX_CH-1:0] req,
                                          input int unsigned       n);
    int unsigned idx;
    int unsigned cand;
    logic        found;
    idx   = prio;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (k < n) begin
        cand = prio + k;
        if (cand >= n) cand = cand - n;
        if (!found && req[cand]) begin
          idx   = cand;
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mc_fifo_rr_arb.sv
// -----------------------------------------------------------------------------
// mc_fifo_rr_arb
//   Round-robin channel arbiter for mc_fifo_rr. Grants the first requesting
//   channel at or after the priority pointer. The priority pointer moves to
//   granted+1 (mod NUM_CH) only when en_i is high and a grant is made.
//   Ports:
//     clk_i, rst_i  clock, synchronous active-high reset (priority -> 0)
//     req_i         per-channel request vector
//     en_i          grant is consumed this cycle (advances priority)
//     gnt_o         onehot grant (all zero when no request)
//     gnt_idx_o     index of the granted channel
//     gnt_valid_o   at least one request is present
// -----------------------------------------------------------------------------
module mc_fifo_rr_arb
  import mc_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IdxW   = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [IdxW-1:0]   prio_q, prio_d;
  logic [MAX_CH-1:0] req_ext;

  always_comb begin
    req_ext               = '0;
    req_ext[NUM_CH-1:0]   = req_i;
    gnt_valid_o           = |req_i;
    gnt_idx_o             = IdxW'(rr_next(32'(prio_q), req_ext, NUM_CH));
    gnt_o                 = gnt_valid_o ? (NUM_CH'(1) << gnt_idx_o) : '0;
  end

  always_comb begin
    prio_d = prio_q;
    if (en_i && gnt_valid_o) begin
      if (32'(gnt_idx_o) + 32'd1 >= NUM_CH) prio_d = '0;
      else                                  prio_d = gnt_idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= '0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/mc_fifo_rr.sv
// -----------------------------------------------------------------------------
// mc_fifo_rr
//   Single-clock multi-channel FIFO: NUM_CH independent queues of
//   2**LOG_DEPTH entries each, one channel-tagged write port and one
//   registered read port fed by a round-robin arbiter over the channels.
//
//   Handshakes (valid/ready): a transfer happens on a rising edge where both
//   valid and ready are high. src_ready_o depends only on registered state and
//   src_ch_i. dst_data_o/dst_ch_o hold steady while dst_valid_o & !dst_ready_i.
//
//   Ports:
//     clk_i        clock (rising edge)
//     rst_i        synchronous active-high reset, overrides all inputs
//     flush_i      per-channel flush pulse (empties the channel's storage)
//     src_data_i   write payload
//     src_ch_i     write channel
//     src_valid_i  write request
//     src_ready_o  selected channel exists and is not full
//     dst_data_o   read payload (registered)
//     dst_ch_o     channel of dst_data_o (registered)
//     dst_valid_o  output register holds a word
//     dst_ready_i  consumer accepts
//     fill_o       per-channel storage occupancy (only with MC_FIFO_FILL_EN)
//     ch_empty_o   per-channel storage empty (output register not included)
//     ch_full_o    per-channel storage full
//
//   Build option: define MC_FIFO_FILL_EN to add the fill_o port.
// -----------------------------------------------------------------------------
module mc_fifo_rr
  import mc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter type         T         = logic [WIDTH-1:0],
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned LOG_DEPTH = 2,
  localparam int unsigned IdxW     = $clog2(NUM_CH)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CH-1:0]               flush_i,
  input  T                                src_data_i,
  input  logic [IdxW-1:0]                 src_ch_i,
  input  logic                            src_valid_i,
  output logic                            src_ready_o,
  output T                                dst_data_o,
  output logic [IdxW-1:0]                 dst_ch_o,
  output logic                            dst_valid_o,
  input  logic                            dst_ready_i,
`ifdef MC_FIFO_FILL_EN
  output logic [NUM_CH-1:0][LOG_DEPTH:0]  fill_o,
`endif
  output logic [NUM_CH-1:0]               ch_empty_o,
  output logic [NUM_CH-1:0]               ch_full_o
);

  localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
  localparam int unsigned PtrW  = LOG_DEPTH + 1;
  localparam int unsigned AddrW = IdxW + LOG_DEPTH;
  localparam int unsigned PadCh = 2 ** IdxW;

  // Per-channel binary pointers with one extra wrap bit.
  logic [PtrW-1:0] wptr_q [NUM_CH];
  logic [PtrW-1:0] wptr_d [NUM_CH];
  logic [PtrW-1:0] rptr_q [NUM_CH];
  logic [PtrW-1:0] rptr_d [NUM_CH];

  // Flat storage: channel c owns entries [c*DEPTH +: DEPTH]. No reset on data.
  T mem_q [NUM_CH*DEPTH];

  logic [NUM_CH-1:0] empty, full;
  logic [PadCh-1:0]  full_pad, flush_pad;
  logic              ch_ok, push, pop, load_en;
  logic [LOG_DEPTH-1:0] wr_slot, rd_slot;
  logic [AddrW-1:0]  wr_addr, rd_addr;

  logic [NUM_CH-1:0] req, gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid;

  T                  dst_data_q;
  logic [IdxW-1:0]   dst_ch_q;
  logic              dst_valid_q;

  // ---------------------------------------------------------------------------
  // Status from registered pointers only.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c] = ptr_empty(MAX_PW'(wptr_q[c]), MAX_PW'(rptr_q[c]), LOG_DEPTH);
      full[c]  = ptr_full(MAX_PW'(wptr_q[c]), MAX_PW'(rptr_q[c]), LOG_DEPTH);
    end
  end

  assign ch_empty_o = empty;
  assign ch_full_o  = full;

  // Pad per-channel vectors to 2**IdxW so an out-of-range src_ch_i (possible
  // when NUM_CH is not a power of two) indexes a defined bit.
  always_comb begin
    full_pad               = '0;
    full_pad[NUM_CH-1:0]   = full;
    flush_pad              = '0;
    flush_pad[NUM_CH-1:0]  = flush_i;
  end

  // ---------------------------------------------------------------------------
  // Write side. A flush on the target channel drops the write.
  // ---------------------------------------------------------------------------
  assign ch_ok       = (32'(src_ch_i) < NUM_CH);
  assign src_ready_o = ch_ok & ~full_pad[src_ch_i];
  assign push        = src_valid_i & src_ready_o & ~flush_pad[src_ch_i];

  always_comb begin
    wr_slot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_ch_i == IdxW'(c)) wr_slot = wptr_q[c][LOG_DEPTH-1:0];
    end
  end

  assign wr_addr = {src_ch_i, wr_slot};

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_addr] <= src_data_i;
  end

  // ---------------------------------------------------------------------------
  // Read side: the output register loads whenever it is empty or being
  // consumed. Channels being flushed this cycle cannot be granted.
  // ---------------------------------------------------------------------------
  assign load_en = ~dst_valid_q | dst_ready_i;
  assign req     = ~empty & ~flush_i;

  mc_fifo_rr_arb #(
    .NUM_CH (NUM_CH),
    .IdxW   (IdxW)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req),
    .en_i        (load_en),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign pop = load_en & gnt_valid;

  always_comb begin
    rd_slot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_idx == IdxW'(c)) rd_slot = rptr_q[c][LOG_DEPTH-1:0];
    end
  end

  assign rd_addr = {gnt_idx, rd_slot};

  // ---------------------------------------------------------------------------
  // Pointer next-state. Flush clears both pointers and wins over push/pop.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      if (flush_i[c]) begin
        wptr_d[c] = '0;
        rptr_d[c] = '0;
      end else begin
        if (push && (src_ch_i == IdxW'(c))) wptr_d[c] = wptr_q[c] + PtrW'(1);
        if (pop && gnt[c])                  rptr_d[c] = rptr_q[c] + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. With no candidate it empties only if it was consumed
  // (load_en covers both the empty and the consumed case).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
      dst_ch_q    <= '0;
    end else if (load_en) begin
      if (gnt_valid) begin
        dst_valid_q <= 1'b1;
        dst_data_q  <= mem_q[rd_addr];
        dst_ch_q    <= gnt_idx;
      end else begin
        dst_valid_q <= 1'b0;
      end
    end
  end

  assign dst_valid_o = dst_valid_q;
  assign dst_data_o  = dst_data_q;
  assign dst_ch_o    = dst_ch_q;

`ifdef MC_FIFO_FILL_EN
  // Occupancy from registered pointers; modular subtraction yields 0..DEPTH.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      fill_o[c] = wptr_q[c] - rptr_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_mc_fifo_rr.sv
module tb_mc_fifo_rr;

  localparam int NUM_CH    = 4;
  localparam int LOG_DEPTH = 2;
  localparam int DEPTH     = 4;
  localparam int WIDTH     = 8;
  localparam int W         = 2 + WIDTH;  // {ch, data}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NUM_CH-1:0] flush;
  logic [WIDTH-1:0]  src_data;
  logic [1:0]        src_ch;
  logic              src_valid;
  logic              src_ready;
  logic [WIDTH-1:0]  dst_data;
  logic [1:0]        dst_ch;
  logic              dst_valid;
  logic              dst_ready;
  logic [NUM_CH-1:0] ch_empty;
  logic [NUM_CH-1:0] ch_full;
`ifdef MC_FIFO_FILL_EN
  logic [NUM_CH-1:0][LOG_DEPTH:0] fill;
`endif

  mc_fifo_rr #(
    .WIDTH     (WIDTH),
    .NUM_CH    (NUM_CH),
    .LOG_DEPTH (LOG_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .src_data_i  (src_data),
    .src_ch_i    (src_ch),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .dst_data_o  (dst_data),
    .dst_ch_o    (dst_ch),
    .dst_valid_o (dst_valid),
    .dst_ready_i (dst_ready),
`ifdef MC_FIFO_FILL_EN
    .fill_o      (fill),
`endif
    .ch_empty_o  (ch_empty),
    .ch_full_o   (ch_full)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model (per-channel queues, RR pointer)
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     got_q[$];
  logic [WIDTH-1:0] mq[NUM_CH][$];
  bit               m_valid = 1'b0;
  int               m_prio  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every rising edge using the inputs the DUT sees.
  always @(posedge clk) begin : model
    bit load, found, rdy;
    int g;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_valid = 1'b0;
      m_prio  = 0;
      exp_q.delete();
    end else begin
      rdy   = (int'(src_ch) < NUM_CH) && (mq[src_ch].size() < DEPTH);
      load  = !m_valid || dst_ready;
      found = 1'b0;
      g     = 0;
      if (load) begin
        for (int k = 0; k < NUM_CH; k++) begin
          int c;
          c = (m_prio + k) % NUM_CH;
          if (!found && mq[c].size() > 0 && !flush[c]) begin
            found = 1'b1;
            g     = c;
          end
        end
        if (found) begin
          exp_q.push_back({2'(g), mq[g].pop_front()});
          m_valid = 1'b1;
          m_prio  = (g + 1) % NUM_CH;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (src_valid && rdy && !flush[src_ch]) mq[src_ch].push_back(src_data);
      for (int c = 0; c < NUM_CH; c++) if (flush[c]) mq[c].delete();
    end
  end

  // Monitor: compares status every cycle and pops exp_q on each handshake.
  always @(negedge clk) begin : monitor
    logic [NUM_CH-1:0] ee, ef;
    logic [W-1:0]      e;
    for (int c = 0; c < NUM_CH; c++) begin
      ee[c] = (mq[c].size() == 0);
      ef[c] = (mq[c].size() == DEPTH);
    end
    check("dst_valid", 32'(dst_valid), 32'(m_valid));
    check("ch_empty", 32'(ch_empty), 32'(ee));
    check("ch_full", 32'(ch_full), 32'(ef));
    check("src_ready", 32'(src_ready), 32'(mq[src_ch].size() < DEPTH));
`ifdef MC_FIFO_FILL_EN
    for (int c = 0; c < NUM_CH; c++) check("fill", 32'(fill[c]), 32'(mq[c].size()));
`endif
    if (dst_valid && dst_ready && !rst) begin
      got_q.push_back({dst_ch, dst_data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch%0d %0h expected nothing at %0t",
                 dst_ch, dst_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("dst_word", 32'({dst_ch, dst_data}), 32'(e));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit v, input logic [1:0] ch, input logic [7:0] d,
                     input bit rdy, input logic [3:0] fl);
    src_valid = v;
    src_ch    = ch;
    src_data  = d;
    dst_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 8'h00, rdy, 4'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n, 1'b0);
    rst = 1'b0;
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] t3_exp [6];
    rst = 1'b1; flush = '0; src_data = '0; src_ch = '0; src_valid = 1'b0; dst_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_valid", 32'(dst_valid), 32'd0);
    check("reset_empty", 32'(ch_empty), 32'hF);
    check("reset_full", 32'(ch_full), 32'h0);
    check("reset_data", 32'(dst_data), 32'h0);
    check("reset_ch", 32'(dst_ch), 32'h0);

    // Fill ch2 behind an occupied output register, then drain.
    cyc(1'b1, 2'd0, 8'h11, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd2, 8'hA0 + 8'(i), 1'b0, 4'h0);
    check("t2_full2", 32'(ch_full[2]), 32'd1);
    src_valid = 1'b0; src_ch = 2'd2; #1;
    check("t2_ready_ch2", 32'(src_ready), 32'd0);
    src_ch = 2'd0; #1;
    check("t2_ready_ch0", 32'(src_ready), 32'd1);
    cyc(1'b1, 2'd2, 8'hA4, 1'b0, 4'h0);
    got_q.delete();
    idle(8, 1'b1);
    check("t2_count", 32'(got_q.size()), 32'd5);
    if (got_q.size() == 5) begin
      check("t2_w0", 32'(got_q[0]), 32'({2'd0, 8'h11}));
      for (int i = 0; i < 4; i++) check("t2_wa", 32'(got_q[i+1]), 32'({2'd2, 8'hA0 + 8'(i)}));
    end

    // Round-robin order over ch0, ch1, ch3 at one word per cycle.
    do_reset(1);
    cyc(1'b1, 2'd0, 8'h30, 1'b0, 4'h0);
    cyc(1'b1, 2'd0, 8'h31, 1'b0, 4'h0);
    cyc(1'b1, 2'd1, 8'h32, 1'b0, 4'h0);
    cyc(1'b1, 2'd1, 8'h33, 1'b0, 4'h0);
    cyc(1'b1, 2'd3, 8'h34, 1'b0, 4'h0);
    cyc(1'b1, 2'd3, 8'h35, 1'b0, 4'h0);
    t3_exp = '{{2'd0, 8'h30}, {2'd1, 8'h32}, {2'd3, 8'h34},
               {2'd0, 8'h31}, {2'd1, 8'h33}, {2'd3, 8'h35}};
    got_q.delete();
    idle(6, 1'b1);
    check("t3_count", 32'(got_q.size()), 32'd6);
    if (got_q.size() == 6)
      for (int i = 0; i < 6; i++) check("t3_order", 32'(got_q[i]), 32'(t3_exp[i]));
    check("t3_drained", 32'(dst_valid), 32'd0);

    // Latency of a single write into an idle FIFO.
    cyc(1'b1, 2'd1, 8'h5C, 1'b1, 4'h0);
    check("t4_valid_t1", 32'(dst_valid), 32'd0);
    cyc(1'b0, 2'd0, 8'h00, 1'b1, 4'h0);
    check("t4_valid_t2", 32'(dst_valid), 32'd1);
    check("t4_data", 32'(dst_data), 32'h5C);
    check("t4_ch", 32'(dst_ch), 32'd1);
    idle(2, 1'b1);

    // Full ch1 popped in the same cycle still reports not-ready.
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'd1, 8'h50 + 8'(i), 1'b0, 4'h0);
    check("t5_full1", 32'(ch_full[1]), 32'd1);
    src_valid = 1'b1; src_ch = 2'd1; src_data = 8'h55; dst_ready = 1'b1; flush = '0; #1;
    check("t5_ready_full_pop", 32'(src_ready), 32'd0);
    @(posedge clk); #1;
    check("t5_ready_next", 32'(src_ready), 32'd1);
    idle(6, 1'b1);
    // Push+pop on ch3 keeps occupancy at 2.
    cyc(1'b1, 2'd3, 8'h60, 1'b0, 4'h0);
    cyc(1'b1, 2'd3, 8'h61, 1'b0, 4'h0);
    cyc(1'b1, 2'd3, 8'h62, 1'b0, 4'h0);
    cyc(1'b1, 2'd3, 8'h63, 1'b1, 4'h0);
    check("t5_ch3_nonempty", 32'(ch_empty[3]), 32'd0);
    check("t5_ch3_notfull", 32'(ch_full[3]), 32'd0);
`ifdef MC_FIFO_FILL_EN
    check("t5_fill3", 32'(fill[3]), 32'd2);
`endif
    idle(6, 1'b1);

    // Flush ch0 with a concurrent write; output-register word survives.
    cyc(1'b1, 2'd0, 8'h70, 1'b0, 4'h0);
    cyc(1'b1, 2'd0, 8'h71, 1'b0, 4'h0);
    cyc(1'b1, 2'd0, 8'h72, 1'b0, 4'h0);
    cyc(1'b1, 2'd0, 8'h73, 1'b0, 4'h0);
    cyc(1'b1, 2'd0, 8'hEE, 1'b0, 4'b0001);
    check("t6_empty0", 32'(ch_empty[0]), 32'd1);
    got_q.delete();
    idle(4, 1'b1);
    check("t6_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t6_word", 32'(got_q[0]), 32'({2'd0, 8'h70}));

    // Reset in the middle of random traffic discards everything.
    for (int i = 0; i < 100; i++)
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
          1'($urandom_range(0, 3) == 0), 4'h0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1, 4'h0);
    rst = 1'b0;
    check("t1_valid", 32'(dst_valid), 32'd0);
    check("t1_empty", 32'(ch_empty), 32'hF);
    got_q.delete();
    idle(6, 1'b1);
    check("t1_lost", 32'(got_q.size()), 32'd0);

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 31) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      rst = ($urandom_range(0, 499) == 0);
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
          1'($urandom_range(0, 2) != 0), fl);
    end
    rst = 1'b0;
    idle(24, 1'b1);
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_valid", 32'(dst_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
